spi_slave: RTL and testbench
============================

# spi_slave

Bus-attached SPI target peripheral that lets an external SPI master exchange bytes with the core. It is the responder counterpart of the SoC `spi` master block. It occupies one RIB slave port and is programmed by the core through four word registers. All SPI pins are oversampled in the single `clk` domain.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk_i`, `spi_ss_i` and `spi_mosi_i`; legal values are 2 or 3.

Ports:
- `clk`, in, 1: system clock; the only clock in the block.
- `rst`, in, 1: asynchronous, active-high reset.
- `we_i`, in, 1: RIB write strobe.
- `addr_i`, in, 32: RIB address; only `[3:2]` are decoded.
- `data_i`, in, 32: RIB write data.
- `data_o`, out, 32: RIB read data, combinational from `addr_i`.
- `spi_clk_i`, in, 1: SCLK from the external master.
- `spi_ss_i`, in, 1: slave select, active low.
- `spi_mosi_i`, in, 1: master-out data.
- `spi_miso_o`, out, 1: slave-out data.
- `spi_miso_oe`, out, 1: MISO output enable; 1 only while selected and enabled.
- `int_sig_o`, out, 1: level interrupt.

## Operation
Register map (word offsets):
- 0x0 CTRL, RW:
  - bit0 EN.
  - bit1 CPOL.
  - bit2 CPHA.
  - bit3 IE, RX interrupt enable.
- 0x4 STATUS:
  - bit0 RXV, RX byte valid.
  - bit1 TXP, TX byte pending.
  - bit2 OVR, overrun.
  - bit3 BUSY, `ss` low and EN=1.
  - Writing 1 to bit0 or bit2 clears that bit; other bits are read-only.
- 0x8 TXDATA, W:
  - `data_i[7:0]` goes to `tx_buf` and sets TXP.
  - Reads return `{24'h0, tx_buf}`.
- 0xC RXDATA, R: returns `{24'h0, rx_buf}`; reading has no side effects.

Edge and pin conditioning:
- Synchronized SCLK is edge-detected.
- Leading edge: SCLK leaves the CPOL idle level. Trailing edge: SCLK returns to it.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Transfers are MSB first, 8-bit frames. `bit_cnt` is 3 bits.

State machine:
- IDLE:
  - Entered on reset, or when synced `ss`=1 or EN=0.
  - `bit_cnt`=0; MISO not driven.
  - Goes to LOAD on a falling edge of synced `ss` while EN=1.
- LOAD (1 cycle):
  - `tx_shift` takes `tx_buf` if TXP=1, else 8'h00; TXP is cleared.
  - If CPHA=0, `spi_miso_o` is driven with `tx_shift[7]` immediately.
  - Goes to SHIFT.
- SHIFT:
  - On a sample edge: `rx_shift <= {rx_shift[6:0], mosi}`; `bit_cnt++`.
  - On a shift edge: `spi_miso_o` takes the next `tx_shift` bit. With CPHA=0 the first shift edge of a byte moves to bit 6; with CPHA=1 the first leading edge drives bit 7.
  - When the sample edge completes bit 7 (`bit_cnt` wraps 7->0):
    - `rx_buf <= {rx_shift[6:0], mosi}`.
    - If RXV was already 1, OVR is set and `rx_buf` is overwritten anyway.
    - RXV is set.
    - Goes to LOAD for the next byte; multi-byte frames are allowed while `ss` stays low.
  - `ss` rising mid-byte: abort to IDLE, partial byte discarded, RXV/OVR unchanged, `tx_buf`/TXP unchanged.
- `int_sig_o` = EN & IE & RXV, registered.

Simultaneous events:
- Bus W1C of RXV in the same cycle that a byte completes: set wins (RXV=1).
- TXDATA write in the same cycle as LOAD: LOAD uses the old `tx_buf`. The new value is kept and TXP=1 afterwards.

Reset:
- Clears all registers.
- Outputs after reset: `data_o` per the addressed register (all zero), `spi_miso_o`=0, `spi_miso_oe`=0, `int_sig_o`=0.
- Reset asserted mid-transfer returns to IDLE in the same cycle.

## Timing
- Requires `clk` >= 8x SCLK frequency. SCLK high and low phases must each be >= 4 `clk`.
- Pin-to-action latency: SYNC_STAGES+1 cycles from an SCLK/SS pin edge to the internal edge pulse.
- MISO update:
  - `spi_miso_o` changes 1 cycle after the internal shift-edge pulse.
  - Total pin-to-MISO delay is SYNC_STAGES+2 `clk`, which the master must tolerate before its sample edge.
- `spi_miso_oe` rises 1 cycle after the LOAD state and falls 1 cycle after IDLE is entered.
- Bus side:
  - Writes take effect on the clock edge where `we_i`=1.
  - `data_o` is valid in the same cycle as `addr_i`.
- RXV and `rx_buf` update 1 cycle after the internal sample pulse of bit 7. `int_sig_o` follows 1 cycle later.
- `ss` must be high for >= SYNC_STAGES+2 `clk` to be recognised as deselected.

## Test plan
- **Mode 0 single byte:**
  - Setup: CTRL=0x9, TXDATA=0xA5; master sends 0x3C in mode 0.
  - Required: master receives 0xA5; RXDATA=0x3C; STATUS=0x1 after `ss` rises; `int_sig_o`=1.
  - Then writing STATUS=0x1 drops `int_sig_o` within 2 cycles.
- **Modes 1–3:** repeat the exchange 0x5A<->0xC3 with CPOL/CPHA = 01, 10, 11; both directions are byte-exact in every mode.
- **Two bytes in one `ss` frame, no new TXDATA:**
  - Setup: master sends 0x11 then 0x22; TXDATA=0x77 preloaded.
  - Required: master receives 0x77 then 0x00; OVR=1; RXDATA=0x22.
- **Abort:**
  - Setup: `ss` rises after 5 SCLK edges.
  - Required: RXV stays 0; `bit_cnt` returns to 0; a following full byte 0x81 is received correctly.
- **Simultaneous set/clear:** W1C of RXV in the byte-completion cycle leaves RXV=1.
- **Async reset mid-byte:** `spi_miso_oe`=0, STATUS=0 and CTRL=0 immediately; with EN=0, SCLK activity is ignored.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target with a four-register bus port; pins are oversampled and edge-detected in clk.
// Actions trail pin edges by SYNC_STAGES+1 clk; no backpressure, a new RX byte overwrites rx_buf and flags OVR.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        spi_clk_i,
  input  logic        spi_ss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe,
  output logic        int_sig_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;

  logic [3:0] r_ctrl;
  logic       r_rxv;
  logic       r_txp;
  logic       r_ovr;
  logic [7:0] r_tx_buf;
  logic [7:0] r_rx_buf;
  logic [7:0] r_tx_shift;
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic       r_miso;
  logic       r_oe;
  logic       r_int;

  logic       w_en, w_cpol, w_cpha, w_ie;
  logic       w_sclk, w_ss, w_mosi;
  logic       w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic       w_sample, w_shift, w_ss_fall, w_active, w_busy;
  logic       w_load, w_sample_act, w_shift_act, w_byte_done;
  logic       w_wr_ctrl, w_wr_status, w_wr_tx;
  logic [7:0] w_tx_src;
  logic       w_unused_bits;

  assign w_en   = r_ctrl[0];
  assign w_cpol = r_ctrl[1];
  assign w_cpha = r_ctrl[2];
  assign w_ie   = r_ctrl[3];

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_lead      = w_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = w_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = w_cpha ? w_trail : w_lead;
  assign w_shift     = w_cpha ? w_lead : w_trail;
  assign w_ss_fall   = ~w_ss & r_ss_prev;
  assign w_active    = ~w_ss & w_en;
  assign w_busy      = ~w_ss & w_en;

  // With CPHA=0 the MSB is already on MISO from LOAD, so the trailing edge that
  // closes the previous byte must not advance the new byte.
  assign w_load       = (r_state == ST_LOAD) && w_active;
  assign w_sample_act = (r_state == ST_SHIFT) && w_active && w_sample;
  assign w_shift_act  = (r_state == ST_SHIFT) && w_active && w_shift &&
                        (w_cpha || (r_bit_cnt != 3'd0));
  assign w_byte_done  = w_sample_act && (r_bit_cnt == 3'd7);
  assign w_tx_src     = r_txp ? r_tx_buf : 8'h00;

  assign w_wr_ctrl   = we_i && (addr_i[3:2] == 2'd0);
  assign w_wr_status = we_i && (addr_i[3:2] == 2'd1);
  assign w_wr_tx     = we_i && (addr_i[3:2] == 2'd2);

  assign w_unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall && w_en) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_byte_done) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!w_active) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_rxv      <= 1'b0;
      r_txp      <= 1'b0;
      r_ovr      <= 1'b0;
      r_tx_buf   <= '0;
      r_rx_buf   <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= data_i[3:0];
      if (w_wr_tx)   r_tx_buf <= data_i[7:0];

      if (w_wr_tx) begin
        r_txp <= 1'b1;
      end else if (w_load) begin
        r_txp <= 1'b0;
      end

      // Clears first so a completing byte in the same cycle wins.
      if (w_wr_status && data_i[0]) r_rxv <= 1'b0;
      if (w_wr_status && data_i[2]) r_ovr <= 1'b0;
      if (w_byte_done) begin
        r_rxv    <= 1'b1;
        r_rx_buf <= {r_rx_shift, w_mosi};
        if (r_rxv) r_ovr <= 1'b1;
      end

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end

      if (w_load) begin
        if (w_cpha) begin
          r_tx_shift <= w_tx_src;
        end else begin
          r_tx_shift <= {w_tx_src[6:0], 1'b0};
          r_miso     <= w_tx_src[7];
        end
      end

      if (w_sample_act) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end

      if (w_shift_act) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      r_oe  <= (r_state != ST_IDLE);
      r_int <= w_en & w_ie & r_rxv;
    end
  end

  always_comb begin
    data_o = 32'h0;
    case (addr_i[3:2])
      2'd0:    data_o = {28'h0, r_ctrl};
      2'd1:    data_o = {28'h0, w_busy, r_ovr, r_txp, r_rxv};
      2'd2:    data_o = {24'h0, r_tx_buf};
      default: data_o = {24'h0, r_rx_buf};
    endcase
  end

  assign spi_miso_o  = r_miso;
  assign spi_miso_oe = r_oe;
  assign int_sig_o   = r_int;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master with a scoreboard of expected MISO/RX bytes,
// a per-mode vector table, and hand-built sequences for overrun, abort, set/clear race and reset.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        spi_clk;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_oe;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic       m_cpol;
  logic       m_cpha;
  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  tx;
    logic [7:0]  mo;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we),
    .addr_i      (addr),
    .data_i      (wdata),
    .data_o      (rdata),
    .spi_clk_i   (spi_clk),
    .spi_ss_i    (spi_ss),
    .spi_mosi_i  (spi_mosi),
    .spi_miso_o  (spi_miso),
    .spi_miso_oe (spi_oe),
    .int_sig_o   (irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic check_rx(input string name);
    logic [7:0] e;
    if (exp_rx_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no expected RX byte queued", name);
    end else begin
      // RXDATA holds only the newest byte; older ones were overwritten.
      while (exp_rx_q.size() > 1) e = exp_rx_q.pop_front();
      e = exp_rx_q.pop_front();
      check_reg(name, 32'hC, {24'h0, e});
    end
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input bit w1c_last, output logic [7:0] mi);
    for (int b = 7; b >= 0; b--) begin
      if (!m_cpha) begin
        spi_mosi = mo[b];
        wait_clks(HALF);
        spi_clk = ~m_cpol;
        mi[b] = spi_miso;
        if (w1c_last && b == 0) begin
          // Land the RXV clear on the exact cycle the bit-7 sample pulse completes the byte.
          repeat (SYNC) @(negedge clk);
          addr = 32'h4; wdata = 32'h1; we = 1'b1;
          @(negedge clk);
          we = 1'b0;
          wait_clks(HALF - SYNC - 1);
        end else begin
          wait_clks(HALF);
        end
        spi_clk = m_cpol;
      end else begin
        spi_clk  = ~m_cpol;
        spi_mosi = mo[b];
        wait_clks(HALF);
        spi_clk = m_cpol;
        mi[b] = spi_miso;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic master_byte(input logic [7:0] mo, input bit w1c_last);
    logic [7:0] mi;
    exp_rx_q.push_back(mo);
    spi_xfer(mo, w1c_last, mi);
    if (exp_miso_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL miso_byte: got 0x%0h with no expected byte queued", mi);
    end else begin
      check("miso_byte", {24'h0, mi}, {24'h0, exp_miso_q.pop_front()});
    end
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    wait_clks(6);
    check("miso_oe_selected", {31'h0, spi_oe}, 32'h1);
    wait_clks(2);
  endtask

  task automatic ss_end();
    wait_clks(HALF);
    spi_ss = 1'b1;
    wait_clks(10);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    spi_clk = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 32'h1};
    vecs[1] = '{1'b0, 1'b1, 8'hC3, 8'h5A, 32'h1};
    vecs[2] = '{1'b1, 1'b0, 8'hC3, 8'h5A, 32'h1};
    vecs[3] = '{1'b1, 1'b1, 8'hC3, 8'h5A, 32'h1};

    wait_clks(3);
    check("rst_miso_oe", {31'h0, spi_oe}, 32'h0);
    check("rst_miso", {31'h0, spi_miso}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    check_reg("rst_ctrl", 32'h0, 32'h0);
    check_reg("rst_status", 32'h4, 32'h0);
    check_reg("rst_txdata", 32'h8, 32'h0);
    check_reg("rst_rxdata", 32'hC, 32'h0);

    // One byte per SPI mode.
    for (int i = 0; i < 4; i++) begin
      m_cpol = vecs[i].cpol;
      m_cpha = vecs[i].cpha;
      bus_write(32'h0, {28'h0, 1'b1, vecs[i].cpha, vecs[i].cpol, 1'b1});
      spi_clk = vecs[i].cpol;
      wait_clks(5);
      bus_write(32'h8, {24'h0, vecs[i].tx});
      exp_miso_q.push_back(vecs[i].tx);
      check_reg("txp_pending", 32'h4, 32'h2);
      ss_begin();
      master_byte(vecs[i].mo, 1'b0);
      ss_end();
      check_rx("mode_rxdata");
      check_reg("mode_status", 32'h4, vecs[i].exp_status);
      check("mode_irq", {31'h0, irq}, 32'h1);
      bus_write(32'h4, 32'h1);
      wait_clks(1);
      check("irq_cleared", {31'h0, irq}, 32'h0);
      check_reg("status_cleared", 32'h4, 32'h0);
    end

    // Two bytes in one frame with a single TXDATA write: second byte sends zero, RX overruns.
    m_cpol = 1'b0; m_cpha = 1'b0;
    bus_write(32'h0, 32'h1);
    spi_clk = 1'b0;
    wait_clks(5);
    bus_write(32'h8, 32'h77);
    exp_miso_q.push_back(8'h77);
    exp_miso_q.push_back(8'h00);
    ss_begin();
    master_byte(8'h11, 1'b0);
    master_byte(8'h22, 1'b0);
    ss_end();
    check_rx("two_byte_rxdata");
    check_reg("two_byte_status", 32'h4, 32'h5);
    check("two_byte_irq_ie0", {31'h0, irq}, 32'h0);
    bus_write(32'h4, 32'h5);
    check_reg("two_byte_cleared", 32'h4, 32'h0);

    // Abort after 5 SCLK edges, then a clean byte.
    bus_write(32'h0, 32'h9);
    ss_begin();
    spi_mosi = 1'b1;
    for (int e = 0; e < 5; e++) begin
      wait_clks(HALF);
      spi_clk = ~spi_clk;
    end
    wait_clks(HALF);
    spi_ss = 1'b1;
    wait_clks(4);
    spi_clk = 1'b0;
    wait_clks(10);
    check_reg("abort_status", 32'h4, 32'h0);
    check("abort_irq", {31'h0, irq}, 32'h0);
    check("abort_miso_oe", {31'h0, spi_oe}, 32'h0);
    exp_miso_q.push_back(8'h00);
    ss_begin();
    master_byte(8'h81, 1'b0);
    ss_end();
    check_rx("after_abort_rxdata");
    check_reg("after_abort_status", 32'h4, 32'h1);
    bus_write(32'h4, 32'h5);

    // RXV clear written in the byte-completion cycle: set must win.
    exp_miso_q.push_back(8'h00);
    ss_begin();
    master_byte(8'h42, 1'b1);
    ss_end();
    check_reg("set_wins_status", 32'h4, 32'h1);
    check_rx("set_wins_rxdata");
    bus_write(32'h4, 32'h5);

    // Asynchronous reset in the middle of a byte.
    bus_write(32'h8, 32'h3E);
    ss_begin();
    spi_mosi = 1'b1;
    for (int e = 0; e < 3; e++) begin
      wait_clks(HALF);
      spi_clk = ~spi_clk;
    end
    wait_clks(2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_miso_oe", {31'h0, spi_oe}, 32'h0);
    check("midrst_miso", {31'h0, spi_miso}, 32'h0);
    addr = 32'h4;
    #1;
    check("midrst_status", rdata, 32'h0);
    addr = 32'h0;
    #1;
    check("midrst_ctrl", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    spi_clk = 1'b0;
    for (int e = 0; e < 16; e++) begin
      spi_mosi = e[0];
      wait_clks(HALF);
      spi_clk = ~spi_clk;
    end
    wait_clks(6);
    check("en0_miso_oe", {31'h0, spi_oe}, 32'h0);
    check_reg("en0_status", 32'h4, 32'h0);
    check_reg("en0_rxdata", 32'hC, 32'h0);
    spi_ss = 1'b1;
    wait_clks(10);
    check("en0_irq", {31'h0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
